// File: rtl/dcache_data_array.sv
// dcache_data_array: WAYS x 2^IDX_LEN store of LINE_W-bit lines with one byte-masked CPU port and a refill sequencer.
// Latency: a read returns all ways one cycle after acceptance; a write is visible to the next access; a refill commits one cycle after its last beat.
// Backpressure: acc_ready_o is low while a refill starts or runs; beat_ready_o is high only while filling; beats are never dropped.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   acc_valid_i/acc_ready_o        access handshake; acc_we_i selects write, acc_way_i picks the written way
//   acc_index_i, acc_wdata_i, acc_wmask_i   set index, write line, byte enables
//   rdata_valid_o, rdata_o         read pulse and all-ways read line (way w at [w*LINE_W +: LINE_W])
//   parity_err_o                   per-way parity error, only high with rdata_valid_o
//   refill_start_i, refill_way_i, refill_index_i   refill launch and target, captured on start
//   beat_valid_i/beat_ready_o, beat_data_i         refill beats, lowest line bits first
//   refill_done_o, busy_o          commit pulse, refill in progress
//
// Optional feature: define DCACHE_PARITY_EN to store one even-parity bit per byte and check it on reads.
module dcache_data_array #(
   parameter int WAYS    = 2,
   parameter int IDX_LEN = 6,
   parameter int LINE_W  = 128,
   parameter int BEAT_W  = 64,
   localparam int WW     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     acc_valid_i,
   output logic                     acc_ready_o,
   input  logic                     acc_we_i,
   input  logic [WW-1:0]            acc_way_i,
   input  logic [IDX_LEN-1:0]       acc_index_i,
   input  logic [LINE_W-1:0]        acc_wdata_i,
   input  logic [LINE_W/8-1:0]      acc_wmask_i,
   output logic                     rdata_valid_o,
   output logic [WAYS*LINE_W-1:0]   rdata_o,
   output logic [WAYS-1:0]          parity_err_o,
   input  logic                     refill_start_i,
   input  logic [WW-1:0]            refill_way_i,
   input  logic [IDX_LEN-1:0]       refill_index_i,
   input  logic                     beat_valid_i,
   output logic                     beat_ready_o,
   input  logic [BEAT_W-1:0]        beat_data_i,
   output logic                     refill_done_o,
   output logic                     busy_o
);

   localparam int SETS   = 1 << IDX_LEN;
   localparam int NB     = LINE_W / BEAT_W;
   localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
   localparam int NBYTES = LINE_W / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WW-1:0]          way_q, way_d;
   logic [IDX_LEN-1:0]     idx_q, idx_d;
   logic [LINE_W-1:0]      buf_q;
   logic                   rdata_valid_q, rdata_valid_d;
   logic [WAYS*LINE_W-1:0] rdata_q, rdata_d;

   logic [LINE_W-1:0]      mem_q [WAYS][SETS];

   logic                   acc_fire;
   logic                   beat_fire;
   logic                   last_beat;

   // Unified array write port, shared by CPU writes and refill commits.
   logic                   wr_en;
   logic [WW-1:0]          wr_way;
   logic [IDX_LEN-1:0]     wr_idx;
   logic [LINE_W-1:0]      wr_data;
   logic [NBYTES-1:0]      wr_mask;

   // A refill start steals the cycle from any access offered alongside it.
   assign acc_ready_o   = (state_q == ST_IDLE) & ~refill_start_i;
   assign acc_fire      = acc_valid_i & acc_ready_o;
   assign beat_ready_o  = (state_q == ST_FILL);
   assign beat_fire     = beat_valid_i & beat_ready_o;
   assign last_beat     = (cnt_q == CW'(NB - 1));
   assign refill_done_o = (state_q == ST_COMMIT);
   assign busy_o        = (state_q != ST_IDLE);
   assign rdata_valid_o = rdata_valid_q;
   assign rdata_o       = rdata_q;

   // Refill sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      way_d   = way_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (refill_start_i) begin
               state_d = ST_FILL;
               cnt_d   = '0;
               way_d   = refill_way_i;
               idx_d   = refill_index_i;
            end
         end
         ST_FILL: begin
            if (beat_fire) begin
               if (last_beat) begin
                  state_d = ST_COMMIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // COMMIT and an accepted access are mutually exclusive, so the mux needs
   // no arbitration; reset suppresses any write in its cycle.
   always_comb begin
      wr_en   = acc_fire & acc_we_i;
      wr_way  = acc_way_i;
      wr_idx  = acc_index_i;
      wr_data = acc_wdata_i;
      wr_mask = acc_wmask_i;
      if (state_q == ST_COMMIT) begin
         wr_en   = 1'b1;
         wr_way  = way_q;
         wr_idx  = idx_q;
         wr_data = buf_q;
         wr_mask = '1;
      end
      if (!rst) begin
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_mask[b]) begin
               mem_q[wr_way][wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Line buffer, filled slot by slot, lowest beat first.
   always_ff @(posedge clk) begin
      if (beat_fire) begin
         buf_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= beat_data_i;
      end
   end

   // Read path: all ways of the set are captured; data holds until the next read.
   always_comb begin
      rdata_valid_d = acc_fire & ~acc_we_i;
      rdata_d       = rdata_q;
      if (rdata_valid_d) begin
         for (int w = 0; w < WAYS; w++) begin
            rdata_d[w*LINE_W +: LINE_W] = mem_q[w][acc_index_i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         way_q         <= '0;
         idx_q         <= '0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         way_q         <= way_d;
         idx_q         <= idx_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
      end
   end

`ifdef DCACHE_PARITY_EN
   logic [NBYTES-1:0] par_q [WAYS][SETS];
   logic [NBYTES-1:0] wr_par;
   logic [WAYS-1:0]   perr_q, perr_d;

   // Even parity: the stored bit makes byte plus parity carry an even count of ones.
   always_comb begin
      wr_par = '0;
      for (int b = 0; b < NBYTES; b++) begin
         wr_par[b] = ^wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_mask[b]) begin
               par_q[wr_way][wr_idx][b] <= wr_par[b];
            end
         end
      end
   end

   always_comb begin
      perr_d = '0;
      for (int w = 0; w < WAYS; w++) begin
         for (int b = 0; b < NBYTES; b++) begin
            perr_d[w] = perr_d[w] |
                        (par_q[w][acc_index_i][b] ^ (^mem_q[w][acc_index_i][8*b +: 8]));
         end
      end
   end

   // Cleared on any non-read cycle so the error is only seen with rdata_valid_o.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perr_q <= '0;
      end else begin
         perr_q <= rdata_valid_d ? perr_d : '0;
      end
   end

   assign parity_err_o = perr_q;
`else
   assign parity_err_o = '0;
`endif

endmodule
